arb_requester: RTL and testbench

- Client-side partner of the 3-way round-less priority arbiter (r[1:3] / g[1:3]); one instance per requester slot k.
- Accepts a job (Start + Len) from local logic, raises Req to the arbiter, waits for Gnt, drives Use for exactly Len cycles, releases, waits for the grant to clear, then pulses Done.
- Guarantees the arbiter returns to Idle between owners, so lower-priority requesters are never starved by back-to-back jobs from the same client.

---
 rtl/arb_requester.sv | 122 ++++++++++++
 tb/tb_arb_requester.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - client-side request/own/release sequencer for the 3-way priority arbiter (optional REQ_TIMEOUT_EN)
module arb_requester #(
    parameter int LW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic [LW-1:0] Len,
    input  logic          Gnt,
    output logic          Req,
    output logic          Use,
    output logic          Busy,
    output logic          Done,
    output logic          Aborted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_OWN  = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [1:0]    state;
    logic [LW-1:0] cnt;
    logic          done_q;

`ifdef REQ_TIMEOUT_EN
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [WW-1:0] wcnt;
    logic          abort_flag;
    logic          aborted_q;
    logic          wait_hit;

    // The wait expires on the TIMEOUT-th ungranted REQ cycle; a grant in that cycle takes priority.
    assign wait_hit = (state == S_REQ) && !Gnt && (wcnt == WW'(TIMEOUT - 1));

    // Wait counter and sticky abort flag; both are cleared while idle so each job starts fresh.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wcnt       <= '0;
            abort_flag <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            aborted_q <= (state == S_REL) && !Gnt && abort_flag;
            case (state)
                S_IDLE: begin
                    wcnt       <= '0;
                    abort_flag <= 1'b0;
                end
                S_REQ: begin
                    if (wait_hit) begin
                        abort_flag <= 1'b1;
                    end else if (!Gnt) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Aborted = aborted_q;
`else
    assign Aborted = 1'b0;
`endif

    // Main sequencer: request, own for Len beats (or until the grant is lost), release, then report.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Len != '0) begin
                            cnt   <= Len;
                            state <= S_REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (Gnt) begin
                        state <= S_OWN;
`ifdef REQ_TIMEOUT_EN
                    end else if (wait_hit) begin
                        state <= S_REL;
`endif
                    end
                end
                S_OWN: begin
                    if (!Gnt || (cnt == LW'(1))) begin
                        state <= S_REL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_REL: begin
                    if (!Gnt) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Req  = (state == S_REQ) || (state == S_OWN);
    assign Use  = (state == S_OWN);
    assign Busy = (state != S_IDLE);
    assign Done = done_q;

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - self-checking bench for arb_requester against an interval-based job model
module tb_arb_requester;

    localparam int LW  = 8;
    localparam int TO  = 15;
    localparam int NBK = 160;

`ifdef REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start  = 1'b0;
    logic [LW-1:0] Len    = '0;
    logic          Gnt    = 1'b0;
    logic          Req, Use, Busy, Done, Aborted;
    logic          blk    = 1'b0;

    int errors = 0;
    int checks = 0;
    bit pd = 1'b0;
    bit pa = 1'b0;

    always #5 Clock = ~Clock;

    arb_requester #(.LW(LW), .TIMEOUT(TO)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Start   (Start),
        .Len     (Len),
        .Gnt     (Gnt),
        .Req     (Req),
        .Use     (Use),
        .Busy    (Busy),
        .Done    (Done),
        .Aborted (Aborted)
    );

    // registered-grant arbiter: grants one cycle after Req unless a higher-priority owner blocks
    always @(posedge Clock) Gnt <= (Req === 1'b1) && !blk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            Start = 1'b0;
            blk   = 1'b0;
            @(negedge Clock);
            chk("idle_req", c, Req, 1'b0);
            chk("idle_use", c, Use, 1'b0);
            chk("idle_busy", c, Busy, 1'b0);
            chk("idle_done", c, Done, (c == 0) ? logic'(pd) : 1'b0);
            chk("idle_abort", c, Aborted, (c == 0) ? logic'(pa) : 1'b0);
            tick();
        end
        pd = 1'b0;
        pa = 1'b0;
    endtask

    // One job, started in cycle 0. bk[c] is the higher-priority-owner blocking in cycle c.
    // Expected behaviour is derived as intervals: Req on [1,E], Use on [G+1,E], Busy on [1,R], Done at R+1.
    task automatic job(input int L, input int H, input int P, input int PL);
        bit bk [NBK];
        int g, e, r;
        bit ab;
        for (int i = 0; i < NBK; i++) bk[i] = (i < H) || (P >= 0 && i >= P && i < P + PL);
        Start = 1'b1;
        Len   = LW'(L);
        blk   = bk[0];
        @(negedge Clock);
        chk("start_req", 0, Req, 1'b0);
        chk("start_use", 0, Use, 1'b0);
        chk("start_busy", 0, Busy, 1'b0);
        chk("start_done", 0, Done, logic'(pd));
        chk("start_abort", 0, Aborted, logic'(pa));
        tick();
        if (L == 0) begin
            Start = 1'b0;
            pd = 1'b1;
            pa = 1'b0;
        end else begin
            ab = 1'b0;
            g  = -1;
            e  = 0;
            for (int c = 1; c < NBK - 2 && g < 0 && !ab; c++) begin
                if (c >= 2 && !bk[c-1]) g = c;
                else if (TO_EN && c == TO) begin
                    ab = 1'b1;
                    e  = c;
                end
            end
            if (!ab) begin
                e = g + L;
                for (int c = g + 1; c <= g + L; c++) begin
                    if (bk[c-1]) begin
                        e = c;
                        break;
                    end
                end
            end
            r = bk[e] ? e + 1 : e + 2;
            for (int c = 1; c <= r; c++) begin
                Start = 1'($urandom);
                Len   = LW'($urandom);
                blk   = bk[c];
                @(negedge Clock);
                chk("req", c, Req, logic'(c <= e));
                chk("use", c, Use, logic'(!ab && c > g && c <= e));
                chk("busy", c, Busy, 1'b1);
                chk("done", c, Done, 1'b0);
                chk("abort", c, Aborted, 1'b0);
                tick();
            end
            Start = 1'b0;
            blk   = 1'b0;
            pd = 1'b1;
            pa = ab;
        end
    endtask

    initial begin
        logic exp_req [1:7];
        logic exp_use [1:7];
        Resetn = 1'b0;
        repeat (3) tick();
        Resetn = 1'b1;
        @(negedge Clock);
        chk("rst_req", 0, Req, 1'b0);
        chk("rst_use", 0, Use, 1'b0);
        chk("rst_busy", 0, Busy, 1'b0);
        chk("rst_done", 0, Done, 1'b0);
        chk("rst_abort", 0, Aborted, 1'b0);
        tick();

        job(3, 0, -1, 0);
        idle(2);
        job(0, 0, -1, 0);
        idle(2);
        job(4, 6, -1, 0);
        idle(1);
        job(6, 0, 4, 3);
        idle(1);
        job(3, 0, -1, 0);
        job(2, 0, -1, 0);
        job(255, 0, -1, 0);
        idle(1);

        exp_req = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_use = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        Start = 1'b1;
        Len   = LW'(5);
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            Resetn = (c == 4) ? 1'b0 : 1'b1;
            @(negedge Clock);
            chk("mrst_req", c, Req, exp_req[c]);
            chk("mrst_use", c, Use, exp_use[c]);
            chk("mrst_busy", c, Busy, logic'(c <= 4));
            chk("mrst_done", c, Done, 1'b0);
            tick();
        end
        Resetn = 1'b1;

`ifdef REQ_TIMEOUT_EN
        job(3, 1000, -1, 0);
        idle(1);
        job(3, 14, -1, 0);
        idle(1);
`endif

        for (int k = 0; k < 40; k++) begin
            int gap;
            int p;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
            p = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 20)) : -1;
            job(int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), p, int'($urandom_range(1, 4)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
